// File: rtl/otp_seg_decoder_pkg.sv
// otp_seg_pkg: shared constants, hex segment table, sample tuple and frame state type
// Contents: SEG_BLANK, anode codes, HEX_SEG table (active-low {g,f,e,d,c,b,a}),
// seg_tuple_t sampled input tuple, frame_state_t frame FSM states.
package otp_seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [1:0] AN_DIG0 = 2'b10;
    localparam logic [1:0] AN_DIG1 = 2'b01;
    localparam logic [1:0] AN_NONE = 2'b11;
    localparam logic [1:0] AN_ILL = 2'b00;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef struct packed {
        logic [1:0] an;
        logic [6:0] lseg;
        logic [6:0] useg;
    } seg_tuple_t;
    localparam seg_tuple_t SEG_IDLE = '{an: AN_NONE, lseg: SEG_BLANK, useg: SEG_BLANK};
    typedef enum logic [1:0] {EMPTY, HAVE0, HAVE1, EMIT} frame_state_t;
endpackage

// File: rtl/otp_seg_decoder_if.sv
// otp_seg_decoder_if: display scan inputs and decoded frame outputs
// master drives an/lfsr_seg/user_seg and observes the frame outputs; slave is the decoder.
interface otp_seg_decoder_if;
    logic [1:0] an;
    logic [6:0] lfsr_seg;
    logic [6:0] user_seg;
    logic [7:0] otp_code;
    logic [7:0] user_code;
    logic code_valid;
    logic match;
    logic blank;
    logic seg_err;
    modport master(
        output an, lfsr_seg, user_seg,
        input otp_code, user_code, code_valid, match, blank, seg_err
    );
    modport slave(
        input an, lfsr_seg, user_seg,
        output otp_code, user_code, code_valid, match, blank, seg_err
    );
endinterface

// File: rtl/otp_seg_decoder_seg_to_hex.sv
// otp_seg_to_hex: combinational active-low seven-segment to hex nibble decoder
// Ports: seg (in, 7), nibble (out, 4), is_blank (out, all segments off), is_bad (out, not in table and not blank).
module otp_seg_to_hex
    import otp_seg_pkg::*;
(
    input logic [6:0] seg,
    output logic [3:0] nibble,
    output logic is_blank,
    output logic is_bad
);
    assign is_blank = seg == SEG_BLANK;
    always_comb begin
        nibble = 4'h0;
        is_bad = seg != SEG_BLANK;
        for (int i = 0; i < 16; i++) begin
            if (seg == HEX_SEG[i]) begin
                nibble = 4'(i);
                is_bad = 1'b0;
            end
        end
    end
endmodule

// File: rtl/otp_seg_decoder.sv
// otp_seg_decoder: debounces scanned seven-segment digits and emits decoded two-digit frames
// Ports: clk, reset_n (sync, active-low), bus (slave modport: an, lfsr_seg, user_seg in;
// otp_code, user_code, code_valid, match, blank, seg_err out).
module otp_seg_decoder
    import otp_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input logic clk,
    input logic reset_n,
    otp_seg_decoder_if.slave bus
);
    localparam logic [7:0] CMAX = 8'(STABLE_CYCLES - 1);
    seg_tuple_t s_q, s_p;
    frame_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt, otp_nxt, usr_nxt, otp_q, usr_q;
    logic [3:0] l_nib, u_nib, o0, o1, u0, u1;
    logic l_blank, u_blank, l_bad, u_bad, b0, b1;
    logic held, eq, hit, bad, cap0, cap1, err, emit, blank_nxt, blank_q, match_q, err_q;

    otp_seg_to_hex u_lfsr (.seg(s_q.lseg), .nibble(l_nib), .is_blank(l_blank), .is_bad(l_bad));
    otp_seg_to_hex u_user (.seg(s_q.useg), .nibble(u_nib), .is_blank(u_blank), .is_bad(u_bad));

    assign eq = s_q == s_p;
    assign cnt_nxt = !eq ? 8'd0 : cnt == CMAX ? CMAX : cnt + 8'd1;
    // held remembers that this hold already fired, so a long hold captures once
    assign hit = eq && cnt_nxt == CMAX && !held;
    assign bad = l_bad || u_bad;
    assign cap0 = hit && s_q.an == AN_DIG0 && !bad;
    assign cap1 = hit && s_q.an == AN_DIG1 && !bad;
    assign err = hit && (s_q.an == AN_ILL || (s_q.an != AN_NONE && bad));
    assign emit = state_nxt == EMIT;
    // outputs load on the capture edge that completes the frame, so merge the incoming digit
    assign otp_nxt = {cap1 ? l_nib : o1, cap0 ? l_nib : o0};
    assign usr_nxt = {cap1 ? u_nib : u1, cap0 ? u_nib : u0};
    assign blank_nxt = (cap1 ? l_blank || u_blank : b1) || (cap0 ? l_blank || u_blank : b0);

    always_comb begin
        state_nxt = state;
        state_nxt = state == EMIT  ? EMPTY :
                    state == EMPTY ? (cap0 ? HAVE0 : cap1 ? HAVE1 : EMPTY) :
                    state == HAVE0 ? (cap1 ? EMIT : HAVE0) :
                                     (cap0 ? EMIT : HAVE1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= EMPTY;
        else state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_q <= SEG_IDLE;
            s_p <= SEG_IDLE;
            cnt <= 8'd0;
            held <= 1'b0;
            {o0, o1, u0, u1, b0, b1} <= '0;
            {otp_q, usr_q, blank_q, match_q, err_q} <= '0;
        end else begin
            s_q <= {bus.an, bus.lfsr_seg, bus.user_seg};
            s_p <= s_q;
            cnt <= cnt_nxt;
            held <= eq && (held || cnt_nxt == CMAX);
            if (cap0) {o0, u0, b0} <= {l_nib, u_nib, l_blank || u_blank};
            if (cap1) {o1, u1, b1} <= {l_nib, u_nib, l_blank || u_blank};
            if (emit) begin
                otp_q <= otp_nxt;
                usr_q <= usr_nxt;
                blank_q <= blank_nxt;
                match_q <= otp_nxt == usr_nxt && !blank_nxt;
            end
            err_q <= err;
        end
    end

    assign bus.otp_code = otp_q;
    assign bus.user_code = usr_q;
    assign bus.code_valid = state == EMIT;
    assign bus.match = match_q;
    assign bus.blank = blank_q;
    assign bus.seg_err = err_q;
endmodule
